// File: rtl/control_ring.sv
// control_ring: alarm ring sequencer producing the beep cadence, stop, snooze and timeout.
// Build option: define CONTROL_RING_SNOOZE_EN to enable the snooze feature.
module control_ring #(
   parameter int HALF_PERIOD   = 50_000_000,
   parameter int RING_HALVES   = 120,
   parameter int SNOOZE_HALVES = 600,
   parameter int SNOOZE_MAX    = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic alarma_on,
   input  logic activring,
   input  logic apagar,
   input  logic posponer,
   output logic buzzer,
   output logic led_ring,
   output logic sonando,
   output logic pospuesto
);

   typedef enum logic [1:0] {
      IDLE,
      BEEP_ON,
      BEEP_OFF,
      SNOOZE
   } state_t;

   localparam logic [26:0] PRE_LAST  = 27'(HALF_PERIOD - 1);
   localparam logic [9:0]  RING_LAST = 10'(RING_HALVES);

   state_t      state;
   logic [26:0] prescaler;
   logic [9:0]  halves;
   logic [9:0]  halves_nxt;
   logic        half_done;
   logic        activring_q;
   logic        apagar_q;
   logic        posponer_q;
   logic        activring_rise;
   logic        apagar_rise;
   logic        snooze_req;
   logic        stop;

   assign activring_rise = activring & ~activring_q;
   assign apagar_rise    = apagar & ~apagar_q;
   assign stop           = ~alarma_on | apagar_rise;
   assign half_done      = prescaler == PRE_LAST;
   assign halves_nxt     = halves + 10'd1;

`ifdef CONTROL_RING_SNOOZE_EN
   localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_HALVES);
   localparam logic [2:0] SNOOZE_LIM  = 3'(SNOOZE_MAX);

   logic [2:0] snoozes;
   logic       posponer_rise;

   assign posponer_rise = posponer & ~posponer_q;
   assign snooze_req    = posponer_rise && (snoozes < SNOOZE_LIM);
   assign pospuesto     = state == SNOOZE;

   always_ff @(posedge clk) begin
      if (reset) begin
         snoozes <= '0;
      end else if (!stop) begin
         if (state == IDLE && activring_rise)
            snoozes <= '0;
         else if ((state == BEEP_ON || state == BEEP_OFF) && snooze_req)
            snoozes <= snoozes + 3'd1;
      end
   end
`else
   logic unused_snooze;

   assign snooze_req    = 1'b0;
   assign pospuesto     = 1'b0;
   assign unused_snooze = ^{posponer, posponer_q,
                            10'(SNOOZE_HALVES), 3'(SNOOZE_MAX)};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         prescaler   <= '0;
         halves      <= '0;
         activring_q <= 1'b0;
         apagar_q    <= 1'b0;
         posponer_q  <= 1'b0;
      end else begin
         activring_q <= activring;
         apagar_q    <= apagar;
         posponer_q  <= posponer;
         if (stop) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (activring_rise) begin
                     state     <= BEEP_ON;
                     prescaler <= '0;
                     halves    <= '0;
                  end
               end
               BEEP_ON, BEEP_OFF: begin
                  // a snooze on the final half-period wins over timeout
                  if (snooze_req) begin
                     state     <= SNOOZE;
                     prescaler <= '0;
                     halves    <= '0;
                  end else if (half_done) begin
                     prescaler <= '0;
                     halves    <= halves_nxt;
                     if (halves_nxt == RING_LAST)
                        state <= IDLE;
                     else if (state == BEEP_ON)
                        state <= BEEP_OFF;
                     else
                        state <= BEEP_ON;
                  end else begin
                     prescaler <= prescaler + 27'd1;
                  end
               end
`ifdef CONTROL_RING_SNOOZE_EN
               SNOOZE: begin
                  if (half_done) begin
                     prescaler <= '0;
                     if (halves_nxt == SNOOZE_LAST) begin
                        state  <= BEEP_ON;
                        halves <= '0;
                     end else begin
                        halves <= halves_nxt;
                     end
                  end else begin
                     prescaler <= prescaler + 27'd1;
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign buzzer   = state == BEEP_ON;
   assign sonando  = (state == BEEP_ON) || (state == BEEP_OFF);
   assign led_ring = state != IDLE;

endmodule

// File: tb/tb_control_ring.sv
// tb_control_ring: randomized and directed checks of control_ring
// against a time-based reference model.
module tb_control_ring;

   localparam int HP = 4;
   localparam int RH = 6;
   localparam int SH = 4;
   localparam int SM = 2;
`ifdef CONTROL_RING_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic alarma_on = 1'b0;
   logic activring = 1'b0;
   logic apagar = 1'b0;
   logic posponer = 1'b0;
   logic buzzer;
   logic led_ring;
   logic sonando;
   logic pospuesto;

   int pass = 0;
   int total = 0;

   // model: 0 idle, 1 ringing, 2 snoozed; start = edge the mode began
   int cyc = 0;
   int m_mode = 0;
   int m_start = 0;
   int m_sn = 0;
   logic p_act = 1'b0;
   logic p_ap = 1'b0;
   logic p_po = 1'b0;

   always #5 clk = ~clk;

   control_ring #(
      .HALF_PERIOD(HP),
      .RING_HALVES(RH),
      .SNOOZE_HALVES(SH),
      .SNOOZE_MAX(SM)
   ) dut (
      .clk(clk),
      .reset(reset),
      .alarma_on(alarma_on),
      .activring(activring),
      .apagar(apagar),
      .posponer(posponer),
      .buzzer(buzzer),
      .led_ring(led_ring),
      .sonando(sonando),
      .pospuesto(pospuesto)
   );

   function automatic logic [3:0] exp_out();
      logic ph;
      if (m_mode == 1) begin
         ph = (((cyc - m_start) / HP) % 2) == 0;
         return {ph, 3'b110};
      end
      if (m_mode == 2)
         return 4'b0101;
      return 4'b0000;
   endfunction

   function automatic logic [3:0] got();
      return {buzzer, led_ring, sonando, pospuesto};
   endfunction

   task automatic tick();
      int c, nm, ns, nsn;
      logic ar, apr, por;
      c = cyc + 1;
      nm = m_mode;
      ns = m_start;
      nsn = m_sn;
      ar = activring & ~p_act;
      apr = apagar & ~p_ap;
      por = posponer & ~p_po;
      if (reset) begin
         nm = 0;
         nsn = 0;
      end else if (!alarma_on || apr) begin
         nm = 0;
      end else if (m_mode == 0) begin
         if (ar) begin
            nm = 1;
            ns = c;
            nsn = 0;
         end
      end else if (m_mode == 1) begin
         if (SNZ_EN && por && m_sn < SM) begin
            nm = 2;
            ns = c;
            nsn = m_sn + 1;
         end else if (c - m_start == RH * HP) begin
            nm = 0;
         end
      end else if (c - m_start == SH * HP) begin
         nm = 1;
         ns = c;
      end
      @(posedge clk);
      cyc = c;
      m_mode = nm;
      m_start = ns;
      m_sn = nsn;
      p_act = reset ? 1'b0 : activring;
      p_ap = reset ? 1'b0 : apagar;
      p_po = reset ? 1'b0 : posponer;
      #1;
   endtask

   task automatic start_clean();
      reset = 1'b1;
      alarma_on = 1'b1;
      activring = 1'b0;
      apagar = 1'b0;
      posponer = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      activring = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (got() !== 4'b0000)
         $display("FAIL reset got=%b exp=0000", got());
      else
         pass++;
      tick();
      total++;
      if (got() !== exp_out())
         $display("FAIL reset_idle got=%b exp=%b", got(), exp_out());
      else
         pass++;
   endtask

   task automatic test_timeout();
      start_clean();
      total++;
      if (buzzer !== 1'b1)
         $display("FAIL timeout_start got=%b exp=1", buzzer);
      else
         pass++;
      for (int i = 1; i < RH * HP; i++) begin
         tick();
         total++;
         if (got() !== exp_out())
            $display("FAIL timeout cyc=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
      tick();
      total++;
      if (got() !== 4'b0000)
         $display("FAIL timeout_end got=%b exp=0000", got());
      else
         pass++;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (got() !== 4'b0000)
            $display("FAIL no_restart i=%0d got=%b exp=0000", i, got());
         else
            pass++;
      end
   endtask

   task automatic test_stop();
      start_clean();
      repeat (5) tick();
      apagar = 1'b1;
      tick();
      total++;
      if (got() !== 4'b0000)
         $display("FAIL stop got=%b exp=0000", got());
      else
         pass++;
      for (int i = 0; i < 12; i++) begin
         if (i == 3)
            apagar = 1'b0;
         tick();
         total++;
         if (got() !== exp_out() || buzzer !== 1'b0)
            $display("FAIL stop_hold i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
   endtask

   task automatic test_snooze();
      start_clean();
      tick();
      posponer = 1'b1;
      tick();
      posponer = 1'b0;
      total++;
      if (pospuesto !== SNZ_EN || buzzer !== !SNZ_EN)
         $display("FAIL snooze_enter got=%b%b exp=%b%b",
                  pospuesto, buzzer, SNZ_EN, !SNZ_EN);
      else
         pass++;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (got() !== exp_out())
               $display("FAIL snooze n=%0d i=%0d got=%b exp=%b",
                        n, i, got(), exp_out());
            else
               pass++;
         end
         posponer = 1'b1;
         tick();
         posponer = 1'b0;
         total++;
         if (got() !== exp_out())
            $display("FAIL snooze_req n=%0d got=%b exp=%b", n, got(), exp_out());
         else
            pass++;
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         total++;
         if (got() !== exp_out())
            $display("FAIL snooze_tail i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
   endtask

   task automatic test_snooze_limit();
      start_clean();
      for (int i = 0; i < 60; i++) begin
         posponer = (i % 5) == 1;
         tick();
         total++;
         if (got() !== exp_out())
            $display("FAIL limit i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
      posponer = 1'b0;
   endtask

   task automatic test_simultaneous();
      start_clean();
      repeat (3) tick();
      apagar = 1'b1;
      posponer = 1'b1;
      tick();
      total++;
      if (got() !== 4'b0000)
         $display("FAIL simul got=%b exp=0000", got());
      else
         pass++;
      apagar = 1'b0;
      posponer = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (pospuesto !== 1'b0 || got() !== exp_out())
            $display("FAIL simul_after i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
   endtask

   task automatic test_enable_reset();
      start_clean();
      repeat (5) tick();
      alarma_on = 1'b0;
      tick();
      total++;
      if (got() !== 4'b0000)
         $display("FAIL enable_drop got=%b exp=0000", got());
      else
         pass++;
      alarma_on = 1'b1;
      activring = 1'b0;
      tick();
      activring = 1'b1;
      tick();
      posponer = 1'b1;
      tick();
      posponer = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      activring = 1'b0;
      tick();
      reset = 1'b0;
      total++;
      if (got() !== 4'b0000)
         $display("FAIL reset_mid got=%b exp=0000", got());
      else
         pass++;
      tick();
      activring = 1'b1;
      for (int i = 0; i < RH * HP + 4; i++) begin
         tick();
         total++;
         if (got() !== exp_out())
            $display("FAIL restart i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
      total++;
      if (led_ring !== 1'b0)
         $display("FAIL restart_end got=%b exp=0", led_ring);
      else
         pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         reset = $urandom_range(0, 299) == 0;
         alarma_on = $urandom_range(0, 149) != 0;
         if ($urandom_range(0, 39) == 0)
            activring = ~activring;
         apagar = $urandom_range(0, 79) == 0;
         if ($urandom_range(0, 9) == 0)
            posponer = ~posponer;
         tick();
         total++;
         if (got() !== exp_out())
            $display("FAIL random i=%0d got=%b exp=%b", i, got(), exp_out());
         else
            pass++;
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_stop();
      test_snooze();
      test_snooze_limit();
      test_simultaneous();
      test_enable_reset();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
